// File: rtl/rtc_secuenciador_accesos.sv
// Transaction scheduler for the RTC bus-timing generator: single-register writes,
// N_RD-register read scans, idle gaps. Optional RTC_TIMEOUT_EN adds a per-access timeout.
module rtc_secuenciador_accesos #(
  parameter int          N_RD    = 6,
  parameter logic [7:0]  RD_BASE = 8'h21,
  parameter int          GAP     = 2,
  parameter int          TIMEOUT = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_rdy,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic [8*N_RD-1:0] rd_data,
  output logic              rd_valid,
  input  logic              cambio_est,
  input  logic              dat1,
  input  logic [7:0]        bus_din,
  output logic              en_esc,
  output logic              en_lect,
  output logic [7:0]        dir_out,
  output logic [7:0]        dato_out,
  output logic              busy,
  output logic              err
);

  localparam int IW = $clog2(N_RD) + 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_WR_ACC, S_RD_ACC, S_GAP} state_t;

  state_t            state_q, state_d;
  logic              wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d, scan_q, scan_d;
  logic              wr_rdy_q, wr_rdy_d, wr_ack_q, wr_ack_d, rd_valid_q, rd_valid_d;
  logic              err_q, err_d, en_esc_q, en_esc_d, en_lect_q, en_lect_d;
  logic              dat1_q, cap_q, cap_d;
  logic [7:0]        wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [7:0]        dir_q, dir_d, dato_q, dato_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [8*N_RD-1:0] rd_data_q, rd_data_d;
  logic              tmo_hit, go_wr, go_rd;

`ifdef RTC_TIMEOUT_EN
  logic [6:0] tmo_cnt_q;

  // Counter is zero whenever an access state is entered, since those are only reached from IDLE/GAP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= 7'd0;
    end else if (state_q == S_WR_ACC || state_q == S_RD_ACC) begin
      tmo_cnt_q <= tmo_cnt_q + 7'd1;
    end else begin
      tmo_cnt_q <= 7'd0;
    end
  end

  assign tmo_hit = (tmo_cnt_q == 7'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      scan_q     <= 1'b0;
      wr_rdy_q   <= 1'b1;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      en_esc_q   <= 1'b0;
      en_lect_q  <= 1'b0;
      dat1_q     <= 1'b0;
      cap_q      <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      dir_q      <= 8'd0;
      dato_q     <= 8'd0;
      idx_q      <= '0;
      gap_q      <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      scan_q     <= scan_d;
      wr_rdy_q   <= wr_rdy_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      en_esc_q   <= en_esc_d;
      en_lect_q  <= en_lect_d;
      dat1_q     <= dat1;
      cap_q      <= cap_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      dir_q      <= dir_d;
      dato_q     <= dato_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_pend_d  = wr_pend_q;
    rd_pend_d  = rd_pend_q;
    scan_d     = scan_q;
    wr_rdy_d   = wr_rdy_q;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    en_esc_d   = en_esc_q;
    en_lect_d  = en_lect_q;
    cap_d      = cap_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    dir_d      = dir_q;
    dato_d     = dato_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    rd_data_d  = rd_data_q;
    go_wr      = 1'b0;
    go_rd      = 1'b0;

    // wr_rdy follows wr_pend one cycle late, so it reopens the cycle after ack/abort
    if (wr_req && wr_rdy_q) begin
      wr_pend_d = 1'b1;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      wr_rdy_d  = 1'b0;
    end else if (!wr_pend_q) begin
      wr_rdy_d = 1'b1;
    end
    if (rd_req) begin
      rd_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_pend_q) begin
          go_wr = 1'b1;
        end else if (rd_pend_q) begin
          idx_d  = '0;
          scan_d = 1'b1;
          go_rd  = 1'b1;
        end
      end
      S_WR_ACC: begin
        if (cambio_est) begin
          en_esc_d  = 1'b0;
          wr_ack_d  = 1'b1;
          wr_pend_d = 1'b0;
          gap_d     = '0;
          state_d   = S_GAP;
        end else if (tmo_hit) begin
          en_esc_d  = 1'b0;
          err_d     = 1'b1;
          wr_pend_d = 1'b0;
          gap_d     = '0;
          state_d   = S_GAP;
        end
      end
      S_RD_ACC: begin
        if (dat1_q && !dat1 && !cap_q) begin
          for (int i = 0; i < N_RD; i++) begin
            if (idx_q == IW'(i)) rd_data_d[8*i +: 8] = bus_din;
          end
          cap_d = 1'b1;
        end
        if (cambio_est) begin
          en_lect_d = 1'b0;
          idx_d     = idx_q + 1'b1;
          gap_d     = '0;
          state_d   = S_GAP;
        end else if (tmo_hit) begin
          en_lect_d = 1'b0;
          err_d     = 1'b1;
          rd_pend_d = 1'b0;
          scan_d    = 1'b0;
          gap_d     = '0;
          state_d   = S_GAP;
        end
      end
      default: begin
        if (gap_q != GW'(GAP - 1)) begin
          gap_d = gap_q + 1'b1;
        end else if (wr_pend_q) begin
          go_wr = 1'b1;
        end else if (scan_q && idx_q < IW'(N_RD)) begin
          go_rd = 1'b1;
        end else if (scan_q) begin
          rd_valid_d = 1'b1;
          rd_pend_d  = 1'b0;
          scan_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    if (go_wr) begin
      state_d  = S_WR_ACC;
      en_esc_d = 1'b1;
      dir_d    = wr_addr_q;
      dato_d   = wr_data_q;
    end
    if (go_rd) begin
      state_d   = S_RD_ACC;
      en_lect_d = 1'b1;
      cap_d     = 1'b0;
      dir_d     = RD_BASE + 8'(idx_d);
    end
  end

  assign wr_rdy   = wr_rdy_q;
  assign wr_ack   = wr_ack_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;
  assign en_esc   = en_esc_q;
  assign en_lect  = en_lect_q;
  assign dir_out  = dir_q;
  assign dato_out = dato_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtc_secuenciador_accesos.sv
// Directed bench for rtc_secuenciador_accesos with a behavioural timing-generator model
// and a bus monitor that logs every access start.
module tb_rtc_secuenciador_accesos;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [7:0]  wr_addr = 8'd0, wr_data = 8'd0;
  logic        wr_rdy, wr_ack, rd_valid, en_esc, en_lect, busy, err;
  logic [47:0] rd_data;
  logic        cambio_est = 1'b0, dat1 = 1'b0;
  logic [7:0]  bus_din = 8'd0, dir_out, dato_out;

  int n_checks = 0, n_fail = 0;
  int ack_cnt = 0, valid_cnt = 0, err_cnt = 0, both_viol = 0, gap_viol = 0;
  int mcnt = 0, high_run = 0, low_run = 0, last_len = 0;
  logic       en_prev = 1'b0, seen = 1'b0, hang;
  logic [7:0] hang_addr = 8'hFF, data_base = 8'h10;
  logic [8:0] acc_log[$];
  logic [7:0] wdat_log[$];

  always #5 clk = ~clk;

  rtc_secuenciador_accesos dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_ack(wr_ack), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .cambio_est(cambio_est), .dat1(dat1), .bus_din(bus_din), .en_esc(en_esc), .en_lect(en_lect),
    .dir_out(dir_out), .dato_out(dato_out), .busy(busy), .err(err)
  );

  // Timing generator: end of cycle after 27 enabled cycles, data window on cycles 5..14
  always @(negedge clk) begin
    if (en_esc || en_lect) mcnt = mcnt + 1; else mcnt = 0;
    hang       = en_lect && (dir_out == hang_addr);
    cambio_est = (mcnt == 27) && !hang;
    dat1       = en_lect && (mcnt >= 5) && (mcnt < 15) && !hang;
    bus_din    = en_lect ? data_base + (dir_out - 8'h21) : 8'h00;
  end

  always @(negedge clk) begin
    if (wr_ack) ack_cnt = ack_cnt + 1;
    if (rd_valid) valid_cnt = valid_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
    if (en_esc && en_lect) both_viol = both_viol + 1;
    if (en_esc || en_lect) begin
      if (!en_prev) begin
        if (seen && low_run < 2) gap_viol = gap_viol + 1;
        acc_log.push_back({en_esc, dir_out});
        wdat_log.push_back(dato_out);
        seen = 1'b1;
        high_run = 0;
      end
      high_run = high_run + 1;
      low_run = 0;
    end else begin
      if (en_prev) last_len = high_run;
      low_run = low_run + 1;
    end
    en_prev = en_esc || en_lect;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic pulse_wr(input logic [7:0] a, input logic [7:0] d, input logic with_rd);
    wr_addr = a; wr_data = d; wr_req = 1'b1; rd_req = with_rd;
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic run_until(input string tag, input int max_cyc, input int a, input int v, input int e);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack_cnt >= a && valid_cnt >= v && err_cnt >= e && !busy) && n < max_cyc);
    check_eq(tag, 64'(n < max_cyc), 64'd1);
  endtask

  task automatic check_log(input string tag, input logic [8:0] exp[]);
    check_eq({tag, "_len"}, 64'(acc_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < acc_log.size(); i++)
      check_eq($sformatf("%s_acc%0d", tag, i), 64'(acc_log[i]), 64'(exp[i]));
  endtask

  initial begin
    int a0, v0, e0, n;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_en_esc", 64'(en_esc), 64'd0);
    check_eq("rst_en_lect", 64'(en_lect), 64'd0);
    check_eq("rst_wr_rdy", 64'(wr_rdy), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_flags", 64'({wr_ack, rd_valid, err}), 64'd0);
    check_eq("rst_rd_data", 64'(rd_data), 64'd0);
    check_eq("rst_dir_dato", 64'({dir_out, dato_out}), 64'd0);

    // 1: single write
    pulse_wr(8'h22, 8'h45, 1'b0);
    check_eq("t1_wr_rdy_low", 64'(wr_rdy), 64'd0);
    run_until("t1_done", 200, 1, 0, 0);
    check_log("t1", '{9'h122});
    check_eq("t1_dato", 64'(wdat_log[0]), 64'h45);
    check_eq("t1_len", 64'(last_len), 64'd27);
    check_eq("t1_ack_cnt", 64'(ack_cnt), 64'd1);
    check_eq("t1_wr_rdy", 64'(wr_rdy), 64'd1);

    // 2: full scan
    acc_log.delete(); wdat_log.delete();
    pulse_rd();
    run_until("t2_done", 600, 1, 1, 0);
    check_log("t2", '{9'h021, 9'h022, 9'h023, 9'h024, 9'h025, 9'h026});
    check_eq("t2_rd_data", 64'(rd_data), 64'h151413121110);
    check_eq("t2_valid_cnt", 64'(valid_cnt), 64'd1);

    // 3: write interleaved during read idx 2
    acc_log.delete(); wdat_log.delete();
    pulse_rd();
    n = 0;
    while (!(en_lect && dir_out == 8'h23) && n < 300) begin @(negedge clk); n++; end
    check_eq("t3_reach_idx2", 64'(n < 300), 64'd1);
    pulse_wr(8'h23, 8'h12, 1'b0);
    run_until("t3_done", 800, 2, 2, 0);
    check_log("t3", '{9'h021, 9'h022, 9'h023, 9'h123, 9'h024, 9'h025, 9'h026});
    if (wdat_log.size() > 3) check_eq("t3_wr_dato", 64'(wdat_log[3]), 64'h12);
    check_eq("t3_rd_data", 64'(rd_data), 64'h151413121110);

    // 4: simultaneous requests, second write ignored
    acc_log.delete(); wdat_log.delete();
    pulse_wr(8'h30, 8'h5A, 1'b1);
    pulse_wr(8'h31, 8'h66, 1'b0);
    run_until("t4_done", 800, 3, 3, 0);
    repeat (40) @(negedge clk);
    check_log("t4", '{9'h130, 9'h021, 9'h022, 9'h023, 9'h024, 9'h025, 9'h026});
    check_eq("t4_ack_cnt", 64'(ack_cnt), 64'd3);
    check_eq("t4_valid_cnt", 64'(valid_cnt), 64'd3);
    check_eq("t4_wr_rdy", 64'(wr_rdy), 64'd1);

`ifdef RTC_TIMEOUT_EN
    // 5: read idx 1 never completes
    acc_log.delete(); wdat_log.delete();
    hang_addr = 8'h22; data_base = 8'h80;
    pulse_rd();
    run_until("t5_done", 600, 3, 3, 1);
    check_eq("t5_err_cnt", 64'(err_cnt), 64'd1);
    check_eq("t5_valid_cnt", 64'(valid_cnt), 64'd3);
    check_eq("t5_len", 64'(last_len), 64'd60);
    check_eq("t5_rd_data", 64'(rd_data), 64'h151413121180);
    check_log("t5", '{9'h021, 9'h022});
    hang_addr = 8'hFF; data_base = 8'h10;
`endif

    // 6: reset during write access
    a0 = ack_cnt; v0 = valid_cnt; e0 = err_cnt;
    pulse_wr(8'h40, 8'h77, 1'b0);
    n = 0;
    while (!en_esc && n < 20) begin @(negedge clk); n++; end
    check_eq("t6_en_esc_up", 64'(en_esc), 64'd1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("t6_en_esc_drop", 64'(en_esc), 64'd0);
    check_eq("t6_wr_rdy", 64'(wr_rdy), 64'd1);
    check_eq("t6_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("t6_no_ack", 64'(ack_cnt - a0), 64'd0);
    check_eq("t6_no_valid_err", 64'((valid_cnt - v0) + (err_cnt - e0)), 64'd0);
    check_eq("t6_idle", 64'({busy, en_esc, en_lect}), 64'd0);

    check_eq("both_enables", 64'(both_viol), 64'd0);
    check_eq("gap_violations", 64'(gap_viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_secuenciador_accesos.md
Name: rtc_secuenciador_accesos

Overview:
Transaction scheduler in front of the RTC bus-timing generator (the block producing CS/WR/RD/AD, the address/data window flags and the end-of-cycle flag).
- Arbitrates between a single-register write requester (time/date setting) and a periodic read scan of N_RD consecutive RTC registers.
- Drives the generator's write/read enables and address/data bytes, and captures read data.
- Waits for the end-of-cycle flag, then enforces an idle gap between transactions.

Parameters:
N_RD, 6, number of registers read per scan (1..16)
RD_BASE, 8'h21, address of first scanned register; slot i reads RD_BASE+i
GAP, 2, cycles enables held low between transactions (min 1)
TIMEOUT, 60, max cycles waiting for cambio_est per transaction

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low (0 = reset)
wr_req  in  1  write request pulse; accepted only when wr_rdy=1
wr_addr  in  8  write address, sampled with wr_req
wr_data  in  8  write data, sampled with wr_req
wr_rdy  out  1  1 = can accept wr_req
wr_ack  out  1  1-cycle pulse, write completed
rd_req  in  1  scan request pulse
rd_data  out  8*N_RD  slot i at bits [8i+7:8i]
rd_valid  out  1  1-cycle pulse, full scan completed
cambio_est  in  1  end-of-cycle flag from timing generator
dat1  in  1  data-window flag from timing generator
bus_din  in  8  RTC data bus input
en_esc  out  1  write enable to timing generator
en_lect  out  1  read enable to timing generator
dir_out  out  8  address byte to bus driver
dato_out  out  8  write data byte to bus driver
busy  out  1  1 when FSM not IDLE
err  out  1  1-cycle timeout pulse

Behaviour:
- Reset (async, reset=0) values: FSM IDLE; en_esc, en_lect, wr_ack, rd_valid, err, busy = 0; wr_rdy=1; rd_data, dir_out, dato_out = 0; pending flags cleared.
- A reset mid-transaction drops the enables immediately and discards everything pending.
- wr_req with wr_rdy=1:
  - Latch wr_addr/wr_data; set wr_pend; wr_rdy=0 next cycle.
  - wr_rdy returns to 1 the cycle after wr_ack or after a timeout abort.
  - wr_req while wr_rdy=0 is ignored.
- rd_req sets rd_pend. rd_req while rd_pend is set or a scan is active is ignored (merged).
- FSM states:
  - IDLE: wr_pend has priority over rd_pend. Write goes to WR_ACC. A scan goes to RD_ACC with idx=0. All registered, so the enable rises 1 cycle after the request is seen.
  - WR_ACC: en_esc=1, dir_out=latched addr, dato_out=latched data. On cambio_est=1: en_esc=0 next cycle, wr_ack pulse on that same cycle, clear wr_pend, go to GAP.
  - RD_ACC: en_lect=1, dir_out=RD_BASE+idx.
    - When dat1 was 1 last cycle and is 0 now, capture bus_din into slot idx. At most one capture per transaction.
    - On cambio_est=1: en_lect=0 next cycle, idx++, go to GAP.
  - GAP: enables low for GAP cycles, then:
    - wr_pend → WR_ACC, which interleaves the write inside a scan; the scan resumes at the current idx afterwards.
    - else scan active and idx<N_RD → RD_ACC.
    - else scan just finished → rd_valid pulse, clear rd_pend, IDLE.
    - else → IDLE.
- en_esc and en_lect are never 1 simultaneously.
- Enables are never re-raised without at least GAP low cycles in between.
- Slots are updated individually as captured. rd_valid signals that all N_RD slots hold data from the same scan.
- idx width is clog2(N_RD)+1. idx reaching N_RD ends the scan with no wrap.

Optional Feature:
RTC_TIMEOUT_EN
- Defined: a 7-bit counter clears on entry to WR_ACC/RD_ACC and increments each cycle in those states.
- When the count reaches TIMEOUT with no cambio_est:
  - Enable drops next cycle and err pulses for 1 cycle.
  - A write is discarded: no wr_ack, wr_rdy returns to 1.
  - A scan is aborted entirely: no rd_valid, rd_pend cleared, unread slots keep their old values.
  - FSM goes to GAP, then proceeds normally.
- Not defined: no counter; err tied to 0; the FSM waits indefinitely for cambio_est.

Test Plan:
1. After reset release, wr_req with addr 8'h22, data 8'h45; model asserts cambio_est 27 cycles after en_esc rises → en_esc high 27 cycles, dir_out=22, dato_out=45, wr_ack 1 pulse, wr_rdy back to 1, busy low after GAP=2.
2. rd_req; model returns bus_din=8'h10+i on each dat1 fall → addresses 21..26 in order, each separated by 2 low-enable cycles; rd_data slot i = 10+i; single rd_valid pulse after the 6th read.
3. rd_req, then wr_req (addr 8'h23, data 8'h12) during read idx 2 → read 2 completes, write executes next, reads resume at idx 3 (address 24); both wr_ack and rd_valid pulse.
4. wr_req and rd_req in the same cycle → write first, then full scan. Second wr_req while wr_rdy=0 → ignored, exactly one write seen on the bus.
5. With RTC_TIMEOUT_EN, model never asserts cambio_est during read idx 1 → en_lect drops after 60 cycles, err pulses once, no rd_valid, slot 0 updated, slots 1..5 unchanged.
6. reset pulled low mid-WR_ACC → en_esc 0 the same cycle, wr_rdy=1, busy=0; no wr_ack after release.
